// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: issue (S1) and result (S2) registers around the shared ALU, Z/V/N flags, branch resolution, HLT drain.
// Define EX_FLAG_BYPASS_EN to let a branch resolve against the flags S1 is writing this cycle, instead of stalling behind it.
module alu_exec_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [2:0]  in_ccc,
    input  logic [3:0]  in_rd,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    input  logic [15:0] alu_out,
    input  logic        alu_ovfl,
    input  logic        alu_neg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [3:0]  out_opcode,
    output logic [3:0]  out_rd,
    output logic        br_valid,
    output logic        br_taken,
    output logic [2:0]  flags,
    output logic        halted
);

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        s1Valid_q, s1Valid_d;
    logic [3:0]  s1Op_q;
    logic [15:0] s1A_q, s1B_q;
    logic [3:0]  s1Rd_q;
    logic        s2Valid_q, s2Valid_d;
    logic [15:0] s2Result_q;
    logic [3:0]  s2Op_q;
    logic [3:0]  s2Rd_q;
    logic [2:0]  flags_q, flags_d;
    logic        brValid_q, brValid_d;
    logic        brTaken_q, brTaken_d;

    logic        s1Move;
    logic        accept;
    logic        inIsBranch;
    logic        stall;
    logic [2:0]  s1Mask;
    logic [2:0]  branchFlags;

    // Write mask in {Z,V,N} order for each opcode
    function automatic logic [2:0] flagMask(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001:                   flagMask = 3'b111;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: flagMask = 3'b100;
            default:                            flagMask = 3'b000;
        endcase
    endfunction

    function automatic logic branchCond(input logic [2:0] ccc, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (ccc)
            3'b000:  branchCond = ~z;
            3'b001:  branchCond = z;
            3'b010:  branchCond = ~z & ~n;
            3'b011:  branchCond = n;
            3'b100:  branchCond = z | ~n;
            3'b101:  branchCond = n | z;
            3'b110:  branchCond = v;
            default: branchCond = 1'b1;
        endcase
    endfunction

    assign s1Move     = s1Valid_q & (~s2Valid_q | out_ready);
    assign inIsBranch = (in_opcode == OP_B) | (in_opcode == OP_BR);
    assign s1Mask     = flagMask(s1Op_q);

    assign flags_d = s1Move
                   ? ((s1Mask & {~|alu_out, alu_ovfl, alu_neg}) | (~s1Mask & flags_q))
                   : flags_q;

`ifdef EX_FLAG_BYPASS_EN
    // A branch can only be accepted behind S1 when S1 moves, so flags_d is exactly the value it must see
    assign stall       = 1'b0;
    assign branchFlags = flags_d;
`else
    assign stall       = inIsBranch & s1Valid_q & (|s1Mask);
    assign branchFlags = flags_q;
`endif

    assign in_ready = rst_n & (state_q == RUN) & (~s1Valid_q | s1Move) & ~stall;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        s1Valid_d = s1Valid_q;
        s2Valid_d = s2Valid_q;
        brValid_d = accept & inIsBranch;
        brTaken_d = accept & inIsBranch & branchCond(in_ccc, branchFlags);

        if (accept) begin
            s1Valid_d = 1'b1;
        end else if (s1Move) begin
            s1Valid_d = 1'b0;
        end

        if (s1Move) begin
            s2Valid_d = 1'b1;
        end else if (out_ready) begin
            s2Valid_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (accept && (in_opcode == OP_HLT)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (s2Valid_q && out_ready && (s2Op_q == OP_HLT)) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            flags_q   <= 3'b000;
            brValid_q <= 1'b0;
            brTaken_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1Valid_q <= s1Valid_d;
            s2Valid_q <= s2Valid_d;
            flags_q   <= flags_d;
            brValid_q <= brValid_d;
            brTaken_q <= brTaken_d;
        end
    end

    // Payload registers carry no reset; their valid bits qualify them
    always_ff @(posedge clk) begin
        if (accept) begin
            s1Op_q <= in_opcode;
            s1A_q  <= in_a;
            s1B_q  <= in_b;
            s1Rd_q <= in_rd;
        end
        if (s1Move) begin
            s2Result_q <= alu_out;
            s2Op_q     <= s1Op_q;
            s2Rd_q     <= s1Rd_q;
        end
    end

    assign alu_opcode = s1Op_q;
    assign alu_in1    = s1A_q;
    assign alu_in2    = s1B_q;
    assign out_valid  = s2Valid_q;
    assign out_result = s2Result_q;
    assign out_opcode = s2Op_q;
    assign out_rd     = s2Rd_q;
    assign br_valid   = brValid_q;
    assign br_taken   = brTaken_q;
    assign flags      = flags_q;
    assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU attached to the S1 port.
module tb_alu_exec_ctrl;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_LLB = 4'b1010;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

`ifdef EX_FLAG_BYPASS_EN
    localparam int EXP_EQ_STALL = 0;
`else
    localparam int EXP_EQ_STALL = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_a, in_b;
    logic [2:0]  in_ccc;
    logic [3:0]  in_rd;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_in1, alu_in2;
    logic [15:0] alu_out;
    logic        alu_ovfl, alu_neg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_opcode;
    logic [3:0]  out_rd;
    logic        br_valid, br_taken;
    logic [2:0]  flags;
    logic        halted;

    int          checksTotal  = 0;
    int          checksPassed = 0;
    logic        captureEn    = 1'b0;
    logic [15:0] resQ[$];
    logic [3:0]  opQ[$];

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ccc     (in_ccc),
        .in_rd      (in_rd),
        .alu_opcode (alu_opcode),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out),
        .alu_ovfl   (alu_ovfl),
        .alu_neg    (alu_neg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .flags      (flags),
        .halted     (halted)
    );

    // Behavioural ALU: two's-complement add/sub with signed overflow, plus the few logic ops exercised here
    always_comb begin
        alu_out  = alu_in1;
        alu_ovfl = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                alu_out  = alu_in1 + alu_in2;
                alu_ovfl = (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]);
            end
            OP_SUB: begin
                alu_out  = alu_in1 - alu_in2;
                alu_ovfl = (alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15]);
            end
            OP_XOR:  alu_out = alu_in1 ^ alu_in2;
            OP_LLB:  alu_out = {alu_in1[15:8], alu_in2[7:0]};
            default: alu_out = alu_in1;
        endcase
        alu_neg = alu_out[15];
    end

    // Record every output handshake; values at the negedge are the ones the next posedge consumes
    always @(negedge clk) begin
        if (captureEn && rst_n && out_valid && out_ready) begin
            resQ.push_back(out_result);
            opQ.push_back(out_opcode);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Offer one instruction, hold it until accepted, and return just after the accept edge
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] ccc, input logic [3:0] rd, output int waits);
        waits     = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_ccc    = ccc;
        in_rd     = rd;
        #1;
        while (!in_ready && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        logic [15:0] expStream [4];
        expStream[0] = 16'h0013;
        expStream[1] = 16'h0023;
        expStream[2] = 16'h0033;
        expStream[3] = 16'h0043;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = 4'h0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        in_ccc    = 3'b000;
        in_rd     = 4'h0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_br_valid", br_valid, 1'b0);
        checkOutput("rst_br_taken", br_taken, 1'b0);
        checkOutput("rst_flags", flags, 3'b000);
        checkOutput("rst_halted", halted, 1'b0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("run_in_ready", in_ready, 1'b1);

        $display("[TB] ADD overflow");
        applyStimulus(OP_ADD, 16'h7FFF, 16'h0001, 3'b000, 4'h3, w);
        #1;
        checkOutput("s1_alu_opcode", alu_opcode, OP_ADD);
        checkOutput("s1_alu_in1", alu_in1, 16'h7FFF);
        checkOutput("s1_alu_in2", alu_in2, 16'h0001);
        checkOutput("s1_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("add_out_valid", out_valid, 1'b1);
        checkOutput("add_result", out_result, 16'h8000);
        checkOutput("add_rd", out_rd, 4'h3);
        checkOutput("add_flags", flags, 3'b011);
        @(posedge clk);
        #1;
        checkOutput("add_drained", out_valid, 1'b0);

        $display("[TB] SUB then B EQ");
        applyStimulus(OP_SUB, 16'h0005, 16'h0005, 3'b000, 4'h1, w);
        applyStimulus(OP_B, 16'h0000, 16'h0000, 3'b001, 4'h0, w);
        checkOutput("eq_stall_cycles", w, EXP_EQ_STALL);
        #1;
        checkOutput("eq_br_valid", br_valid, 1'b1);
        checkOutput("eq_br_taken", br_taken, 1'b1);
        checkOutput("sub_flags", flags, 3'b100);
        @(posedge clk);
        #1;
        checkOutput("eq_br_pulse", br_valid, 1'b0);

        $display("[TB] flag masks");
        applyStimulus(OP_ADD, 16'h7FFF, 16'h0001, 3'b000, 4'h2, w);
        idle(2);
        checkOutput("pre_xor_flags", flags, 3'b011);
        applyStimulus(OP_XOR, 16'h00F0, 16'h00F0, 3'b000, 4'h2, w);
        idle(2);
        checkOutput("xor_flags", flags, 3'b111);
        applyStimulus(OP_LLB, 16'h1234, 16'h0056, 3'b000, 4'h2, w);
        idle(2);
        checkOutput("llb_flags", flags, 3'b111);
        applyStimulus(OP_B, 16'h0000, 16'h0000, 3'b110, 4'h0, w);
        #1;
        checkOutput("ov_br_valid", br_valid, 1'b1);
        checkOutput("ov_br_taken", br_taken, 1'b1);
        idle(2);
        applyStimulus(OP_B, 16'h0000, 16'h0000, 3'b000, 4'h0, w);
        #1;
        checkOutput("ne_br_valid", br_valid, 1'b1);
        checkOutput("ne_br_taken", br_taken, 1'b0);
        idle(3);

        $display("[TB] backpressured stream");
        resQ.delete();
        opQ.delete();
        captureEn = 1'b1;
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 16'h0010, 16'h0003, 3'b000, 4'h4, w);
        applyStimulus(OP_ADD, 16'h0020, 16'h0003, 3'b000, 4'h5, w);
        in_valid  = 1'b1;
        in_opcode = OP_ADD;
        in_a      = 16'h0030;
        in_b      = 16'h0003;
        repeat (3) begin
            #1;
            checkOutput("bp_in_ready", in_ready, 1'b0);
            checkOutput("bp_out_valid", out_valid, 1'b1);
            checkOutput("bp_out_result", out_result, 16'h0013);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        applyStimulus(OP_ADD, 16'h0030, 16'h0003, 3'b000, 4'h6, w);
        applyStimulus(OP_ADD, 16'h0040, 16'h0003, 3'b000, 4'h7, w);
        idle(4);
        captureEn = 1'b0;
        checkOutput("stream_count", resQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < resQ.size()) begin
                checkOutput($sformatf("stream_res%0d", i), resQ[i], expStream[i]);
            end
        end
        checkOutput("stream_flags", flags, 3'b000);
        applyStimulus(OP_B, 16'h0000, 16'h0000, 3'b010, 4'h0, w);
        #1;
        checkOutput("gt_br_taken", br_taken, 1'b1);
        idle(2);
        applyStimulus(OP_B, 16'h0000, 16'h0000, 3'b011, 4'h0, w);
        #1;
        checkOutput("lt_br_valid", br_valid, 1'b1);
        checkOutput("lt_br_taken", br_taken, 1'b0);
        idle(3);

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 16'h8000, 16'h8000, 3'b000, 4'h8, w);
        applyStimulus(OP_B, 16'h0000, 16'h0000, 3'b111, 4'h0, w);
        #1;
        checkOutput("mid_br_valid", br_valid, 1'b1);
        checkOutput("mid_br_taken", br_taken, 1'b1);
        checkOutput("mid_flags", flags, 3'b110);
        checkOutput("mid_out_valid", out_valid, 1'b1);
        checkOutput("mid_out_opcode", out_opcode, OP_ADD);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mrst_out_valid", out_valid, 1'b0);
        checkOutput("mrst_flags", flags, 3'b000);
        checkOutput("mrst_halted", halted, 1'b0);
        checkOutput("mrst_br_valid", br_valid, 1'b0);
        checkOutput("mrst_in_ready", in_ready, 1'b0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("mrst_release_ready", in_ready, 1'b1);

        $display("[TB] HLT");
        resQ.delete();
        opQ.delete();
        captureEn = 1'b1;
        applyStimulus(OP_HLT, 16'h0000, 16'h0000, 3'b000, 4'h0, w);
        in_valid  = 1'b1;
        in_opcode = OP_ADD;
        in_a      = 16'h0001;
        in_b      = 16'h0001;
        #1;
        checkOutput("drain_in_ready", in_ready, 1'b0);
        checkOutput("drain_halted", halted, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("hlt_out_valid", out_valid, 1'b1);
        checkOutput("hlt_out_opcode", out_opcode, OP_HLT);
        checkOutput("hlt_pre_halted", halted, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("halted_set", halted, 1'b1);
        repeat (3) begin
            checkOutput("halted_in_ready", in_ready, 1'b0);
            checkOutput("halted_hold", halted, 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        captureEn = 1'b0;
        checkOutput("hlt_out_count", opQ.size(), 1);
        if (opQ.size() > 0) begin
            checkOutput("hlt_out_first", opQ[0], OP_HLT);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
